multicycle_control: RTL and testbench

- Multi-cycle controller that sequences the MIPS DataPath: fetch, decode, execute, memory, writeback.
- Drives all datapath control strobes from a Moore FSM.
- Stalls on a shared instruction/data memory through a memReady handshake.
- Sits beside DataPath. It takes opcode and the ALU zero flag and returns the enables and mux selects.

---
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: a Moore FSM that drives the DataPath strobes.
// Define PERF_COUNTERS_EN to add the cycleCount/instrCount outputs.
module multicycle_control #(
    parameter int OPW = 6
`ifdef PERF_COUNTERS_EN
    , parameter int CNTW = 32
`endif
) (
    input  logic           clock,
    input  logic           resetN,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           memReady,
    output logic           pcWrite,
    output logic           pcWriteCond,
    output logic           iorD,
    output logic           memRead,
    output logic           memWrite,
    output logic           irWrite,
    output logic           memToReg,
    output logic           regDst,
    output logic           regWriteEnable,
    output logic           aluSrcA,
    output logic [1:0]     aluSrcB,
    output logic [1:0]     aluOp,
    output logic [1:0]     pcSource,
    output logic           illegalOp
`ifdef PERF_COUNTERS_EN
    , output logic [CNTW-1:0] cycleCount
    , output logic [CNTW-1:0] instrCount
`endif
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_R_EX, S_R_WB, S_ADDR, S_MEM_RD,
        S_MEM_WR, S_LW_WB, S_ADDI_EX, S_ADDI_WB, S_BEQ, S_JUMP
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWriteEnable;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   illegal_q, illegal_d;
    logic   fetch_rdy;

    // Moore decode of a state; registered against the next state so the
    // strobes come straight from flops during the state they belong to.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.memRead = 1'b1; c.aluSrcB = 2'b01; end
            S_DECODE:  c.aluSrcB = 2'b11;
            S_R_EX:    begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
            S_R_WB:    begin c.regDst = 1'b1; c.regWriteEnable = 1'b1; end
            S_ADDR,
            S_ADDI_EX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            S_MEM_RD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
            S_MEM_WR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; end
            S_LW_WB:   begin c.memToReg = 1'b1; c.regWriteEnable = 1'b1; end
            S_ADDI_WB: c.regWriteEnable = 1'b1;
            S_BEQ: begin
                c.aluSrcA = 1'b1; c.aluOp = 2'b01;
                c.pcSource = 2'b01; c.pcWriteCond = 1'b1;
            end
            S_JUMP:    begin c.pcSource = 2'b10; c.pcWrite = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_LW, OP_SW: state_d = S_ADDR;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_R_EX:    state_d = S_R_WB;
            S_ADDR:    state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (memReady) state_d = S_LW_WB;
            S_MEM_WR:  if (memReady) state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_R_WB, S_LW_WB, S_ADDI_WB, S_BEQ, S_JUMP: state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_of(state_d);
            illegal_q <= illegal_d;
        end
    end

    // IR load and PC increment complete with the memory handshake in FETCH.
    assign fetch_rdy      = (state_q == S_FETCH) && memReady;
    assign irWrite        = fetch_rdy;
    assign pcWrite        = ctrl_q.pcWrite | fetch_rdy;
    assign pcWriteCond    = ctrl_q.pcWriteCond;
    assign iorD           = ctrl_q.iorD;
    assign memRead        = ctrl_q.memRead;
    assign memWrite       = ctrl_q.memWrite;
    assign memToReg       = ctrl_q.memToReg;
    assign regDst         = ctrl_q.regDst;
    assign regWriteEnable = ctrl_q.regWriteEnable;
    assign aluSrcA        = ctrl_q.aluSrcA;
    assign aluSrcB        = ctrl_q.aluSrcB;
    assign aluOp          = ctrl_q.aluOp;
    assign pcSource       = ctrl_q.pcSource;
    assign illegalOp      = illegal_q;

    // The branch decision is made in the datapath from pcWriteCond and zero.
    logic unused_zero;
    assign unused_zero = zero;

`ifdef PERF_COUNTERS_EN
    logic [CNTW-1:0] cycle_q, instr_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != S_IDLE) cycle_q <= cycle_q + 1'b1;
            if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
                instr_q <= instr_q + 1'b1;
        end
    end

    assign cycleCount = cycle_q;
    assign instrCount = instr_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, hand-written
// corner sequences, and randomized instructions against a microcode-list model.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       resetN;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWriteEnable, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
`ifdef PERF_COUNTERS_EN
    logic [31:0] cycleCount, instrCount;
`endif

    multicycle_control #(.OPW(6)) dut (
        .clock(clock), .resetN(resetN), .opcode(opcode), .zero(zero),
        .memReady(memReady), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWriteEnable(regWriteEnable), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
        .illegalOp(illegalOp)
`ifdef PERF_COUNTERS_EN
        , .cycleCount(cycleCount), .instrCount(instrCount)
`endif
    );

    always #5 clock = ~clock;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_AI = 6'b001000, OP_BQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    function automatic logic [15:0] pk(input logic pw, pwc, iord, mrd, mwr, irw,
                                       m2r, rdst, rwe, asa,
                                       input logic [1:0] asb, aop, psrc);
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rwe, asa, asb, aop, psrc};
    endfunction

    // Expected strobe sets for each step of an instruction.
    localparam logic [15:0] F1  = pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
    localparam logic [15:0] F0  = pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
    localparam logic [15:0] DEC = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
    localparam logic [15:0] REX = pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
    localparam logic [15:0] RWB = pk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] ADR = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    localparam logic [15:0] MRD = pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] MWR = pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] LWB = pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] AWB = pk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] BEQ = pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
    localparam logic [15:0] JMP = pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [15:0] e;
        logic        ill;
    } vec_t;

    int   checks = 0;
    int   passes = 0;
    logic ill_m  = 1'b0;
    int   m_cyc  = 0;
    int   m_ins  = 0;

    function automatic logic [16:0] act_vec();
        return {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                regDst, regWriteEnable, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // One clock of an instruction: drive inputs on the falling edge, check, then
    // the following rising edge advances the controller.
    task automatic cyc(input logic [5:0] op, input logic mr, input logic [15:0] e,
                       input string nm);
        @(negedge clock);
        opcode   = op;
        memReady = mr;
        #1;
        chk(nm, 32'(act_vec()), 32'({e, ill_m}));
        m_cyc++;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 32'(act_vec()), 32'd0);
`ifdef PERF_COUNTERS_EN
        chk("reset_counters", cycleCount | instrCount, 32'd0);
`endif
        ill_m = 1'b0;
        m_cyc = 0;
        m_ins = 0;
        @(negedge clock);
        resetN = 1'b1;
        #1;
        chk("idle_outputs", 32'(act_vec()), 32'd0);
    endtask

    function automatic logic rnd_mr(input int w);
        return (w >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
    endfunction

    // Reference model: an instruction is a list of steps taken from its
    // opcode class; memory steps repeat until the handshake completes.
    task automatic run_instr(input logic [5:0] op);
        logic mr;
        int   w;
        w = 0;
        do begin
            mr = rnd_mr(w);
            cyc(6'($urandom), mr, mr ? F1 : F0, "rnd_fetch");
            w++;
        end while (!mr);
        cyc(op, 1'($urandom), DEC, "rnd_decode");
        case (op)
            OP_R: begin
                cyc(6'($urandom), 1'($urandom), REX, "rnd_rex");
                cyc(6'($urandom), 1'($urandom), RWB, "rnd_rwb");
            end
            OP_LW, OP_SW: begin
                cyc(op, 1'($urandom), ADR, "rnd_addr");
                w = 0;
                do begin
                    mr = rnd_mr(w);
                    cyc(6'($urandom), mr, (op == OP_LW) ? MRD : MWR, "rnd_mem");
                    w++;
                end while (!mr);
                if (op == OP_LW) cyc(6'($urandom), 1'($urandom), LWB, "rnd_lwwb");
            end
            OP_AI: begin
                cyc(6'($urandom), 1'($urandom), ADR, "rnd_aex");
                cyc(6'($urandom), 1'($urandom), AWB, "rnd_awb");
            end
            OP_BQ:   cyc(6'($urandom), 1'($urandom), BEQ, "rnd_beq");
            OP_J:    cyc(6'($urandom), 1'($urandom), JMP, "rnd_jump");
            default: ill_m = 1'b1;
        endcase
        m_ins++;
    endtask

    initial begin
        vec_t       tbl[$];
        logic [5:0] ops[7];
        resetN   = 1'b0;
        opcode   = '0;
        zero     = 1'b0;
        memReady = 1'b0;

        // R (opcode changes after DECODE must be ignored), lw with two wait
        // states, sw with two wait states, fetch stall, beq, j, illegal, R.
        tbl.push_back('{OP_R, 1'b1, F1, 1'b0});   tbl.push_back('{OP_R, 1'b1, DEC, 1'b0});
        tbl.push_back('{OP_BAD, 1'b1, REX, 1'b0}); tbl.push_back('{OP_BAD, 1'b1, RWB, 1'b0});
        tbl.push_back('{OP_LW, 1'b1, F1, 1'b0});  tbl.push_back('{OP_LW, 1'b1, DEC, 1'b0});
        tbl.push_back('{OP_LW, 1'b1, ADR, 1'b0}); tbl.push_back('{OP_LW, 1'b0, MRD, 1'b0});
        tbl.push_back('{OP_LW, 1'b0, MRD, 1'b0}); tbl.push_back('{OP_LW, 1'b1, MRD, 1'b0});
        tbl.push_back('{OP_LW, 1'b1, LWB, 1'b0});
        tbl.push_back('{OP_SW, 1'b1, F1, 1'b0});  tbl.push_back('{OP_SW, 1'b1, DEC, 1'b0});
        tbl.push_back('{OP_SW, 1'b1, ADR, 1'b0}); tbl.push_back('{OP_SW, 1'b0, MWR, 1'b0});
        tbl.push_back('{OP_SW, 1'b0, MWR, 1'b0}); tbl.push_back('{OP_SW, 1'b1, MWR, 1'b0});
        tbl.push_back('{OP_AI, 1'b0, F0, 1'b0});  tbl.push_back('{OP_AI, 1'b1, F1, 1'b0});
        tbl.push_back('{OP_AI, 1'b1, DEC, 1'b0}); tbl.push_back('{OP_AI, 1'b1, ADR, 1'b0});
        tbl.push_back('{OP_AI, 1'b1, AWB, 1'b0});
        tbl.push_back('{OP_BQ, 1'b1, F1, 1'b0});  tbl.push_back('{OP_BQ, 1'b1, DEC, 1'b0});
        tbl.push_back('{OP_BQ, 1'b1, BEQ, 1'b0});
        tbl.push_back('{OP_J, 1'b1, F1, 1'b0});   tbl.push_back('{OP_J, 1'b1, DEC, 1'b0});
        tbl.push_back('{OP_J, 1'b1, JMP, 1'b0});
        tbl.push_back('{OP_BAD, 1'b1, F1, 1'b0}); tbl.push_back('{OP_BAD, 1'b1, DEC, 1'b0});
        tbl.push_back('{OP_R, 1'b1, F1, 1'b1});   tbl.push_back('{OP_R, 1'b1, DEC, 1'b1});
        tbl.push_back('{OP_R, 1'b1, REX, 1'b1});  tbl.push_back('{OP_R, 1'b1, RWB, 1'b1});
        tbl.push_back('{OP_R, 1'b0, F0, 1'b1});

        do_reset();
        foreach (tbl[i]) begin
            ill_m = tbl[i].ill;
            cyc(tbl[i].op, tbl[i].mr, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Reset asserted mid-store while memory is stalled.
        do_reset();
        cyc(OP_SW, 1'b1, F1, "abort_fetch");
        cyc(OP_SW, 1'b1, DEC, "abort_decode");
        cyc(OP_SW, 1'b1, ADR, "abort_addr");
        cyc(OP_SW, 1'b0, MWR, "abort_memwr");
        resetN = 1'b0;
        #1;
        chk("abort_async_zero", 32'(act_vec()), 32'd0);
        memReady = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("abort_held_zero", 32'(act_vec()), 32'd0);
        end
        @(negedge clock);
        resetN = 1'b1;
        #1;
        chk("abort_idle", 32'(act_vec()), 32'd0);
        cyc(OP_R, 1'b0, F0, "abort_refetch");

        // Ten back-to-back addi instructions with no memory stalls.
        do_reset();
        repeat (10) begin
            cyc(OP_AI, 1'b1, F1, "addi_fetch");
            cyc(OP_AI, 1'b1, DEC, "addi_decode");
            cyc(OP_AI, 1'b1, ADR, "addi_ex");
            cyc(OP_AI, 1'b1, AWB, "addi_wb");
        end
`ifdef PERF_COUNTERS_EN
        @(negedge clock);
        #1;
        chk("perf_instr10", instrCount, 32'd10);
        chk("perf_cycle40", cycleCount, 32'd40);
`endif

        // Randomized instruction stream.
        ops = '{OP_R, OP_LW, OP_SW, OP_AI, OP_BQ, OP_J, 6'b010101};
        do_reset();
        for (int n = 0; n < 60; n++) run_instr(ops[$urandom_range(0, 6)]);
        @(negedge clock);
        #1;
        chk("rnd_illegal_sticky", 32'(illegalOp), 32'(ill_m));
`ifdef PERF_COUNTERS_EN
        chk("rnd_instr_count", instrCount, 32'(m_ins));
        chk("rnd_cycle_count", cycleCount, 32'(m_cyc));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
